// File: rtl/spi_pkg.sv
// Shared types and helpers for the full-duplex SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANS,
    HOLD
  } state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator for SCLK; phase is re-referenced on every start.
module spi_clk_gen #(
  parameter int CLK_DIV = 500,
  parameter int EDGE_W  = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              enable,
  output logic              tick,
  output logic [EDGE_W-1:0] edge_idx
);

  localparam int H     = CLK_DIV / 2;
  localparam int CNT_W = (H > 1) ? $clog2(H) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(H - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      edge_idx <= '0;
    end else if (start) begin
      cnt      <= '0;
      edge_idx <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt      <= '0;
        edge_idx <= edge_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_fd.sv
// Parametrised full-duplex SPI master with decoded chip selects and MSB/LSB ordering.
module spi_master_fd
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int CS_NUM  = 2,
  parameter  int CLK_DIV = 500,
  parameter  int CPOL    = 0,
  parameter  int CPHA    = 0,
  localparam int CS_W    = cs_width(CS_NUM)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   tx_cs,
  input  logic              tx_lsb_first,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_NUM-1:0] cs_n
);

  localparam int         EDGE_W        = $clog2(2 * DATA_W + 3);
  localparam int         IDX_W         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [1:0] MODE          = {1'(CPOL), 1'(CPHA)};
  localparam bit         IDLE_HIGH     = MODE inside {SPI_MODE2, SPI_MODE3};
  localparam bit         SHIFT_LEADING = MODE inside {SPI_MODE1, SPI_MODE3};
  localparam bit         SETUP_DRIVES  = MODE inside {SPI_MODE0, SPI_MODE2};

  state_t              state, state_nxt;
  logic                tick, start;
  logic [EDGE_W-1:0]   edge_idx;
  logic [DATA_W-1:0]   tx_q, rx_sh;
  logic                lsb_q;
  logic [CS_NUM-1:0]   cs_dec;
  int unsigned         k;
  logic                lead, samp_edge, shift_edge;
  logic [IDX_W-1:0]    samp_pos, shift_pos;

  // Position in the word of sequence bit j for the chosen bit order.
  function automatic logic [IDX_W-1:0] bit_pos(input int unsigned j, input logic lsb);
    int unsigned p;
    p = lsb ? j : (DATA_W - 1 - j);
    return IDX_W'(p);
  endfunction

  assign start = (state == IDLE) && tx_valid;

  spi_clk_gen #(.CLK_DIV(CLK_DIV), .EDGE_W(EDGE_W)) u_clk_gen (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .enable   (state != IDLE),
    .tick     (tick),
    .edge_idx (edge_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // The tick that ends SETUP is number 1, so in TRANS edge_idx equals the SCLK edge number.
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) state_nxt = SETUP;
      end
      SETUP: if (tick) state_nxt = TRANS;
      TRANS: if (tick && (edge_idx == EDGE_W'(2 * DATA_W))) state_nxt = HOLD;
      HOLD:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_dec = '1;
    for (int unsigned n = 0; n < CS_NUM; n++) begin
      if (32'(tx_cs) == n) cs_dec[n] = 1'b0;
    end
  end

  always_comb begin
    k          = 32'(edge_idx);
    lead       = edge_idx[0];
    samp_edge  = SHIFT_LEADING ? !lead : lead;
    shift_edge = SHIFT_LEADING ? lead : (!lead && (k != 2 * DATA_W));
    samp_pos   = bit_pos((k - 1) / 2, lsb_q);
    shift_pos  = bit_pos(SHIFT_LEADING ? (k - 1) / 2 : k / 2, lsb_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk     <= IDLE_HIGH;
      mosi     <= 1'b0;
      cs_n     <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_sh    <= '0;
      tx_q     <= '0;
      lsb_q    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: if (tx_valid) begin
          tx_q  <= tx_data;
          lsb_q <= tx_lsb_first;
          cs_n  <= cs_dec;
          sclk  <= IDLE_HIGH;
          rx_sh <= '0;
          mosi  <= SETUP_DRIVES ? tx_data[bit_pos(0, tx_lsb_first)] : 1'b0;
        end
        TRANS: if (tick) begin
          sclk <= ~sclk;
          if (samp_edge)  rx_sh[samp_pos] <= miso;
          if (shift_edge) mosi <= tx_q[shift_pos];
        end
        HOLD: if (tick) begin
          cs_n     <= '1;
          mosi     <= 1'b0;
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fd.sv
// Directed bench for spi_master_fd: four 8-bit mode instances plus one 16-bit/3-CS instance.
module tb_spi_master_fd;

  localparam int N = 5;

  logic        clk;
  logic        rstn;
  logic        tx_valid [N];
  logic [31:0] tx_data  [N];
  logic [2:0]  tx_cs    [N];
  logic        tx_lsb   [N];
  logic        tx_ready [N];
  logic        rx_valid [N];
  logic [31:0] rx_data  [N];
  logic        busy     [N];
  logic        sclk     [N];
  logic        mosi     [N];
  logic [7:0]  cs_n     [N];
  logic [31:0] sl_word  [N];
  logic        sl_lsb   [N];
  logic [31:0] sl_got   [N];
  int          sl_edges [N];
  int          sl_bad   [N];

  int n_chk = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DW     = (g == 4) ? 16 : 8;
    localparam int CSN    = (g == 4) ? 3 : 2;
    localparam int CSW    = (CSN > 1) ? $clog2(CSN) : 1;
    localparam int CPOL_G = (g < 4) ? (g / 2) : 0;
    localparam int CPHA_G = (g < 4) ? (g % 2) : 0;

    logic [DW-1:0]  rxd;
    logic [CSN-1:0] csn;
    logic           rdy_l, rxv_l, busy_l, sclk_l, mosi_l, miso_l;

    spi_master_fd #(
      .DATA_W  (DW),
      .CS_NUM  (CSN),
      .CLK_DIV (4),
      .CPOL    (CPOL_G),
      .CPHA    (CPHA_G)
    ) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .tx_valid     (tx_valid[g]),
      .tx_ready     (rdy_l),
      .tx_data      (tx_data[g][DW-1:0]),
      .tx_cs        (tx_cs[g][CSW-1:0]),
      .tx_lsb_first (tx_lsb[g]),
      .rx_valid     (rxv_l),
      .rx_data      (rxd),
      .busy         (busy_l),
      .sclk         (sclk_l),
      .mosi         (mosi_l),
      .miso         (miso_l),
      .cs_n         (csn)
    );

    assign tx_ready[g] = rdy_l;
    assign rx_valid[g] = rxv_l;
    assign rx_data[g]  = 32'(rxd);
    assign busy[g]     = busy_l;
    assign sclk[g]     = sclk_l;
    assign mosi[g]     = mosi_l;
    assign cs_n[g]     = {{(8 - CSN){1'b1}}, csn};

    // Behavioural slave: watches SCLK one clk after each edge, drives miso, collects mosi.
    logic        busy_q, sclk_q, mosi_q;
    logic [31:0] got;
    int          e, bad;
    int          kk, j, p;
    bit          shifted;

    function automatic logic sbit(input int jj);
      return sl_lsb[g] ? sl_word[g][jj] : sl_word[g][DW - 1 - jj];
    endfunction

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        busy_q <= 1'b0;
        sclk_q <= 1'(CPOL_G);
        mosi_q <= 1'b0;
        miso_l <= 1'b0;
        got    <= '0;
        e      <= 0;
        bad    <= 0;
      end else begin
        busy_q  <= busy_l;
        sclk_q  <= sclk_l;
        mosi_q  <= mosi_l;
        shifted = 1'b0;
        if (busy_l && !busy_q) begin
          e      <= 0;
          got    <= '0;
          bad    <= 0;
          miso_l <= (CPHA_G == 0) ? sbit(0) : 1'b0;
        end else if (busy_l && busy_q) begin
          if (sclk_l != sclk_q) begin
            kk = e + 1;
            e  <= kk;
            if ((CPHA_G == 0) == ((kk % 2) == 1)) begin
              j = (kk - 1) / 2;
              p = sl_lsb[g] ? j : (DW - 1 - j);
              got[p] <= mosi_l;
            end else begin
              shifted = 1'b1;
              j = (CPHA_G == 0) ? (kk / 2) : ((kk - 1) / 2);
              if (j < DW) miso_l <= sbit(j);
            end
          end
          if ((mosi_l != mosi_q) && !shifted) bad <= bad + 1;
        end
      end
    end

    assign sl_got[g]   = got;
    assign sl_edges[g] = e;
    assign sl_bad[g]   = bad;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic exp_cpol(input int i);
    return (i == 2) || (i == 3);
  endfunction

  // One transfer on instance i; returns at the sample point of the rx_valid cycle.
  task automatic xfer(input int i, input logic [31:0] data, input logic [2:0] cs,
                      input logic lsb, input logic [31:0] sw, input logic [7:0] exp_csn,
                      input bit keep_valid, input logic [31:0] next_data);
    int          dw, cyc, dev_cs, dev_rdy;
    logic [31:0] mask;
    dw   = (i == 4) ? 16 : 8;
    mask = (i == 4) ? 32'h0000_FFFF : 32'h0000_00FF;
    sl_word[i]  = sw;
    sl_lsb[i]   = lsb;
    tx_data[i]  = data;
    tx_cs[i]    = cs;
    tx_lsb[i]   = lsb;
    tx_valid[i] = 1'b1;
    @(posedge clk); #1;
    check("accept", {21'd0, busy[i], tx_ready[i], rx_valid[i], cs_n[i]}, {21'd0, 3'b100, exp_csn});
    if (keep_valid) begin
      tx_data[i] = next_data;
    end else begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = ~data;
      tx_lsb[i]   = ~lsb;
      tx_cs[i]    = cs ^ 3'd1;
    end
    cyc = 0; dev_cs = 0; dev_rdy = 0;
    while (!rx_valid[i] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (!rx_valid[i]) begin
        if (cs_n[i] !== exp_csn) dev_cs++;
        if (tx_ready[i] !== 1'b0 || busy[i] !== 1'b1) dev_rdy++;
      end
    end
    check("latency", cyc, (2 * dw + 2) * 2);
    check("rx_data", rx_data[i], sw & mask);
    check("mosi_seq", sl_got[i], data & mask);
    check("cs_n_during", dev_cs, 0);
    check("ready_low", dev_rdy, 0);
    check("sclk_edges", sl_edges[i], 2 * dw);
    check("mosi_stable", sl_bad[i], 0);
    check("end_state", {20'd0, tx_ready[i], busy[i], mosi[i], sclk[i], cs_n[i]},
          {20'd0, 1'b1, 1'b0, 1'b0, exp_cpol(i), 8'hFF});
  endtask

  initial begin
    int cyc;
    rstn = 1'b0;
    for (int i = 0; i < N; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
      tx_cs[i]    = '0;
      tx_lsb[i]   = 1'b0;
      sl_word[i]  = '0;
      sl_lsb[i]   = 1'b0;
    end
    #12;
    check("reset_m0", {22'd0, tx_ready[0], busy[0], rx_valid[0], mosi[0], sclk[0], cs_n[0]},
          {22'd0, 5'b10000, 8'hFF});
    check("reset_m3_sclk", {31'd0, sclk[3]}, 32'd1);
    check("reset_w16", {22'd0, tx_ready[4], busy[4], rx_valid[4], mosi[4], sclk[4], cs_n[4]},
          {22'd0, 5'b10000, 8'hFF});
    check("reset_rx", rx_data[0], 32'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // MSB first then LSB first, mode 0
    xfer(0, 32'hA5, 3'd1, 1'b0, 32'h3C, 8'hFD, 1'b0, 32'h0);
    xfer(0, 32'hA5, 3'd1, 1'b1, 32'h3C, 8'hFD, 1'b0, 32'h0);

    for (int m = 0; m < 4; m++) xfer(m, 32'h81, 3'd0, 1'b0, 32'h7E, 8'hFE, 1'b0, 32'h0);

    // Back-to-back with tx_valid held; the second accept sample also checks the rx_valid pulse width
    xfer(0, 32'h11, 3'd0, 1'b0, 32'hE7, 8'hFE, 1'b1, 32'h22);
    xfer(0, 32'h22, 3'd0, 1'b0, 32'h99, 8'hFE, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a transfer
    sl_word[0]  = 32'hC3;
    sl_lsb[0]   = 1'b0;
    tx_data[0]  = 32'h5A;
    tx_cs[0]    = 3'd1;
    tx_lsb[0]   = 1'b0;
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    cyc = 0;
    while (sl_edges[0] < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_edge5", 32'(sl_edges[0] >= 5), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("async_reset", {22'd0, tx_ready[0], busy[0], rx_valid[0], mosi[0], sclk[0], cs_n[0]},
          {22'd0, 5'b10000, 8'hFF});
    check("async_reset_rx", rx_data[0], 32'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    xfer(0, 32'h5A, 3'd1, 1'b0, 32'hC3, 8'hFD, 1'b0, 32'h0);

    // 16-bit instance, out-of-range chip select
    xfer(4, 32'hBEEF, 3'd3, 1'b0, 32'h1234, 8'hFF, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
